// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: block width, round constants,
// schedule word count and the expansion controller state encoding.
package aes_pkg;

    // Columns per AES state / words per round key
    localparam int NB = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } ks_state_e;

    // Total words in the expanded schedule for a given round count
    function automatic int word_count(input int nr);
        return NB * (nr + 1);
    endfunction

    // Round constant (high byte only) for i/nk = 1..10
    function automatic logic [7:0] rcon(input logic [3:0] j);
        logic [7:0] r;
        r = 8'h00;
        case (j)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse (a^254) followed by the affine map.
// Ports: a = input byte, y = substituted byte.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    always_comb begin
        sq  = 8'h00;
        inv = 8'h00;
        // a^254 = a^2 * a^4 * ... * a^128; zero maps to zero
        sq  = gmul(a, a);
        inv = sq;
        for (int k = 2; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        y = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
    end

endmodule

// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule producing one 32-bit word per clock.
// Ports: clk, reset (async high), start, key[nk*32] -> busy, done, w (full schedule).
module key_expansion_seq
    import aes_pkg::*;
#(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [nk*32-1:0]        key,
    output logic                    busy,
    output logic                    done,
    output logic [0:(nr+1)*128-1]   w
);

    localparam int NW = word_count(nr);
    localparam int IW = $clog2(NW + 1);

    ks_state_e state_q;
    ks_state_e state_d;

    logic [31:0]   words [NW];
    logic [IW-1:0] idx;
    // pos tracks i mod nk, rnd tracks i/nk, avoiding a divider for nk=6
    logic [2:0]    pos;
    logic [3:0]    rnd;

    logic [IW-1:0] cur;
    logic [31:0]   prev;
    logic [31:0]   back;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   temp;
    logic [31:0]   next_word;

    // Controller
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_BUSY;
            ST_BUSY: if (idx == IW'(NW - 1)) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_BUSY);
    assign done = (state_q == ST_DONE);

    // Outside a run the read addresses are parked on valid entries
    assign cur  = busy ? idx : IW'(nk);
    assign prev = words[cur - IW'(1)];
    assign back = words[cur - IW'(nk)];

    assign sub_in = (pos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a (sub_in[b*8 +: 8]),
            .y (sub_out[b*8 +: 8])
        );
    end

    always_comb begin
        temp = prev;
        if (pos == 3'd0)
            temp = sub_out ^ {rcon(rnd), 24'h0};
        else if (nk == 8 && pos == 3'd4)
            temp = sub_out;
    end

    assign next_word = back ^ temp;

    // Datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NW; j++) words[j] <= '0;
            idx <= '0;
            pos <= '0;
            rnd <= '0;
        end else if (start && !busy) begin
            for (int j = 0; j < nk; j++)
                words[j] <= key[(nk-j)*32-1 -: 32];
            idx <= IW'(nk);
            pos <= '0;
            rnd <= 4'd1;
        end else if (busy) begin
            words[cur] <= next_word;
            idx        <= idx + IW'(1);
            if (pos == 3'(nk - 1)) begin
                pos <= '0;
                rnd <= rnd + 4'd1;
            end else begin
                pos <= pos + 3'd1;
            end
        end
    end

    for (genvar i = 0; i < NW; i++) begin : g_w
        assign w[i*32 +: 32] = words[i];
    end

endmodule
